// File: rtl/alu4cpu_pkg.sv
// Shared definitions for the pipelined ALU core:
// opcodes, instruction field positions, flag indices.
package alu4cpu_pkg;

  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int RD_LSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_NOT  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010100;
  localparam logic [5:0] OP_OR   = 6'b010101;
  localparam logic [5:0] OP_XOR  = 6'b010110;
  localparam logic [5:0] OP_ADD  = 6'b010111;
  localparam logic [5:0] OP_SUB  = 6'b011000;
  localparam logic [5:0] OP_MOV  = 6'b011001;
  localparam logic [5:0] OP_SHL  = 6'b011010;
  localparam logic [5:0] OP_SUBI = 6'b011011;
  localparam logic [5:0] OP_SHR  = 6'b011100;
  localparam logic [5:0] OP_ADDI = 6'b011101;
  localparam logic [5:0] OP_MUL  = 6'b011110;
  localparam logic [5:0] OP_SLTI = 6'b011111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product
// per cycle; the load edge already folds in bit 0.
module alu_mul_iter
  import alu4cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          acc_d   = b[0] ? a : '0;
          a_d     = a << 1;
          b_d     = b >> 1;
          cnt_d   = CW'(1);
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q != MUL_IDLE);
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

// File: rtl/alu_core_pipe.sv
// Two-stage ALU core: E1 holds decoded operands,
// E2 executes and writes back, with result bypass.
module alu_core_pipe
  import alu4cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int MUL_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic [XLEN-1:0]          out,
  output logic                     out_valid,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic [3:0]               flags,
  output logic                     illegal,
  output logic                     busy
);

  localparam int RA_W = $clog2(NREGS);
  localparam int SH_W = $clog2(XLEN);
  localparam int MSB  = XLEN - 1;

  logic [XLEN-1:0] rf_q [NREGS];

  logic            e1_valid_q;
  logic [5:0]      e1_op_q;
  logic [RA_W-1:0] e1_rd_q;
  logic [XLEN-1:0] e1_imm_q;
  logic [XLEN-1:0] e1_a_q;
  logic [XLEN-1:0] e1_b_q;

  logic [XLEN-1:0] out_q;
  logic            out_valid_q;
  logic [RA_W-1:0] out_rd_q;
  logic [3:0]      flags_q;
  logic            illegal_q;
  logic [RA_W-1:0] mul_rd_q;

  logic            accept;
  logic [5:0]      f_op;
  logic [RA_W-1:0] f_rd, f_rs, f_rt;
  logic [XLEN-1:0] f_imm;
  logic [XLEN-1:0] rs_val, rt_val;

  logic [XLEN-1:0] ex_res;
  logic            ex_wr, ex_ill, ex_mul;
  logic [1:0]      ex_cv;
  logic [XLEN-1:0] op_b;
  logic [XLEN:0]   sum_w, dif_w;
  logic            add_v, sub_v;

  logic            wb_en;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [1:0]      wb_cv;

  logic            mul_start, mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  logic signed [IMM_W-1:0] imm16;

  assign f_op  = instr[OP_LSB +: OP_W];
  assign f_rd  = instr[RD_LSB +: RA_W];
  assign f_rs  = instr[RS_LSB +: RA_W];
  assign f_rt  = instr[RT_LSB +: RA_W];
  assign imm16 = instr[IMM_LSB +: IMM_W];
  assign f_imm = XLEN'(imm16);

  // Front end stalls from MUL decode until the DONE cycle
  assign instr_ready = !rst
                    && !(e1_valid_q && ex_mul)
                    && !(mul_busy && !mul_done);
  assign accept = instr_valid && instr_ready;

  always_comb begin
    rs_val = rf_q[f_rs];
    if (f_rs == '0) begin
      rs_val = '0;
    end else if (wb_en && wb_rd == f_rs) begin
      rs_val = wb_data;
    end
    rt_val = rf_q[f_rt];
    if (f_rt == '0) begin
      rt_val = '0;
    end else if (wb_en && wb_rd == f_rt) begin
      rt_val = wb_data;
    end
  end

  always_comb begin
    op_b = e1_b_q;
    if (e1_op_q == OP_ADDI || e1_op_q == OP_SUBI) begin
      op_b = e1_imm_q;
    end
    sum_w = {1'b0, e1_a_q} + {1'b0, op_b};
    dif_w = {1'b0, e1_a_q} + {1'b0, ~op_b}
          + (XLEN + 1)'(1);
    add_v = (e1_a_q[MSB] == op_b[MSB])
         && (sum_w[MSB] != e1_a_q[MSB]);
    sub_v = (e1_a_q[MSB] != op_b[MSB])
         && (dif_w[MSB] != e1_a_q[MSB]);
  end

  always_comb begin
    ex_res = '0;
    ex_wr  = 1'b0;
    ex_cv  = 2'b00;
    ex_ill = 1'b0;
    ex_mul = 1'b0;
    if (e1_valid_q) begin
      unique case (e1_op_q)
        OP_NOP: ;
        OP_NOT: begin
          ex_res = ~e1_a_q;
          ex_wr  = 1'b1;
        end
        OP_AND: begin
          ex_res = e1_a_q & e1_b_q;
          ex_wr  = 1'b1;
        end
        OP_OR: begin
          ex_res = e1_a_q | e1_b_q;
          ex_wr  = 1'b1;
        end
        OP_XOR: begin
          ex_res = e1_a_q ^ e1_b_q;
          ex_wr  = 1'b1;
        end
        OP_ADD, OP_ADDI: begin
          ex_res = sum_w[MSB:0];
          ex_cv  = {sum_w[XLEN], add_v};
          ex_wr  = 1'b1;
        end
        OP_SUB, OP_SUBI: begin
          ex_res = dif_w[MSB:0];
          ex_cv  = {dif_w[XLEN], sub_v};
          ex_wr  = 1'b1;
        end
        OP_MOV: begin
          ex_res = e1_a_q;
          ex_wr  = 1'b1;
        end
        OP_SHL: begin
          ex_res = e1_a_q << e1_imm_q[SH_W-1:0];
          ex_wr  = 1'b1;
        end
        OP_SHR: begin
          ex_res = e1_a_q >> e1_imm_q[SH_W-1:0];
          ex_wr  = 1'b1;
        end
        OP_SLTI: begin
          ex_res = XLEN'($signed(e1_a_q)
                 < $signed(e1_imm_q));
          ex_wr  = 1'b1;
        end
        OP_MUL: begin
          if (MUL_EN != 0) ex_mul = 1'b1;
          else             ex_ill = 1'b1;
        end
        default: ex_ill = 1'b1;
      endcase
    end
  end

  assign mul_start = e1_valid_q && ex_mul;

  alu_mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (e1_a_q),
    .b      (e1_b_q),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_prod)
  );

  assign wb_en   = mul_done || ex_wr;
  assign wb_rd   = mul_done ? mul_rd_q : e1_rd_q;
  assign wb_data = mul_done ? mul_prod : ex_res;
  assign wb_cv   = mul_done ? 2'b00 : ex_cv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e1_op_q    <= OP_NOP;
      e1_rd_q    <= '0;
      e1_imm_q   <= '0;
      e1_a_q     <= '0;
      e1_b_q     <= '0;
      mul_rd_q   <= '0;
    end else begin
      e1_valid_q <= accept;
      if (accept) begin
        e1_op_q  <= f_op;
        e1_rd_q  <= f_rd;
        e1_imm_q <= f_imm;
        e1_a_q   <= rs_val;
        e1_b_q   <= rt_val;
      end
      if (mul_start) begin
        mul_rd_q <= e1_rd_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      flags_q     <= 4'b0000;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= wb_en;
      illegal_q   <= e1_valid_q && ex_ill;
      if (wb_en) begin
        out_q    <= wb_data;
        out_rd_q <= wb_rd;
        flags_q[FLAG_N] <= wb_data[MSB];
        flags_q[FLAG_Z] <= (wb_data == '0);
        flags_q[FLAG_C] <= wb_cv[1];
        flags_q[FLAG_V] <= wb_cv[0];
        if (wb_rd != '0) begin
          rf_q[wb_rd] <= wb_data;
        end
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;
  assign busy      = mul_busy;

endmodule

// File: tb/tb_alu_core_pipe.sv
// Directed bench for alu_core_pipe: latency, bypass,
// flags, multiplier stall and reset abort.
module tb_alu_core_pipe;
  import alu4cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] out;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [3:0]  flags;
  logic        illegal;
  logic        busy;

  int vecs = 0;
  int miss = 0;

  alu_core_pipe #(
    .XLEN(32), .NREGS(32), .MUL_EN(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_rd     (out_rd),
    .flags      (flags),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] er(
    logic [5:0] op, int rd, int rs, int rt);
    return {op, 5'(rd), 5'(rs), 5'(rt), 11'd0};
  endfunction

  function automatic logic [31:0] ei(
    logic [5:0] op, int rd, int rs, logic [15:0] im);
    return {op, 5'(rd), 5'(rs), im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input logic [31:0] i,
                      output logic [31:0] o,
                      output logic [4:0] rd,
                      output logic [3:0] f,
                      output logic v);
    instr = i;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = '0;
    tick();
    o = out; rd = out_rd; f = flags; v = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    #10;
    vecs++; if (instr_ready !== 1'b0) begin miss++;
      $display("FAIL rst_ready got %b want 0", instr_ready); end
    vecs++; if (out !== 32'd0 || out_rd !== 5'd0) begin miss++;
      $display("FAIL rst_out got %h/%0d want 0/0", out, out_rd); end
    vecs++; if ({out_valid, illegal, busy} !== 3'b000) begin miss++;
      $display("FAIL rst_pulses got %b want 000",
               {out_valid, illegal, busy}); end
    vecs++; if (flags !== 4'b0000) begin miss++;
      $display("FAIL rst_flags got %b want 0000", flags); end
    #10;
    rst = 1'b0;
    #1;
    vecs++; if (instr_ready !== 1'b1) begin miss++;
      $display("FAIL rel_ready got %b want 1", instr_ready); end
    tick();
  endtask

  task automatic test_addi();
    instr = ei(OP_ADDI, 1, 0, 16'd10);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin miss++;
      $display("FAIL addi_early got %b want 0", out_valid); end
    tick();
    vecs++; if (out_valid !== 1'b1 || out !== 32'd10) begin miss++;
      $display("FAIL addi_out got %b/%h want 1/0000000a",
               out_valid, out); end
    vecs++; if (out_rd !== 5'd1 || flags !== 4'b0000) begin miss++;
      $display("FAIL addi_rdfl got %0d/%b want 1/0000",
               out_rd, flags); end
    tick();
    vecs++; if (out_valid !== 1'b0) begin miss++;
      $display("FAIL addi_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o; logic [4:0] rd;
    logic [3:0] f; logic v;
    run1(ei(OP_ADDI, 1, 0, 16'd99), o, rd, f, v);
    vecs++; if (o !== 32'd99) begin miss++;
      $display("FAIL b2b_pre got %h want 00000063", o); end
    instr = ei(OP_ADDI, 1, 0, 16'd10);
    instr_valid = 1'b1;
    tick();
    instr = ei(OP_SUBI, 2, 1, 16'd2);
    tick();
    instr_valid = 1'b0;
    vecs++; if (out !== 32'd10 || out_rd !== 5'd1 ||
                out_valid !== 1'b1) begin miss++;
      $display("FAIL b2b_first got %h/%0d/%b want a/1/1",
               out, out_rd, out_valid); end
    tick();
    vecs++; if (out !== 32'd8 || out_rd !== 5'd2 ||
                out_valid !== 1'b1) begin miss++;
      $display("FAIL b2b_bypass got %h/%0d/%b want 8/2/1",
               out, out_rd, out_valid); end
    vecs++; if (flags !== 4'b0010) begin miss++;
      $display("FAIL b2b_flags got %b want 0010", flags); end
    run1(er(OP_MOV, 10, 2, 0), o, rd, f, v);
    vecs++; if (o !== 32'd8 || rd !== 5'd10) begin miss++;
      $display("FAIL b2b_r2 got %h/%0d want 8/10", o, rd); end
  endtask

  task automatic test_logic();
    logic [31:0] o; logic [4:0] rd;
    logic [3:0] f; logic v;
    run1(er(OP_NOT, 3, 1, 0), o, rd, f, v);
    vecs++; if (o !== 32'hFFFFFFF5 || f !== 4'b1000) begin miss++;
      $display("FAIL not got %h/%b want fffffff5/1000", o, f); end
    run1(er(OP_AND, 4, 3, 1), o, rd, f, v);
    vecs++; if (o !== 32'd0 || f !== 4'b0100) begin miss++;
      $display("FAIL and got %h/%b want 0/0100", o, f); end
    run1(er(OP_OR, 5, 3, 1), o, rd, f, v);
    vecs++; if (o !== 32'hFFFFFFFF) begin miss++;
      $display("FAIL or got %h want ffffffff", o); end
    run1(er(OP_XOR, 5, 3, 5), o, rd, f, v);
    vecs++; if (o !== 32'h0000000A) begin miss++;
      $display("FAIL xor got %h want 0000000a", o); end
    run1(ei(OP_SLTI, 4, 1, 16'd0), o, rd, f, v);
    vecs++; if (o !== 32'd0 || f !== 4'b0100) begin miss++;
      $display("FAIL slti0 got %h/%b want 0/0100", o, f); end
    run1(ei(OP_SLTI, 4, 1, 16'd11), o, rd, f, v);
    vecs++; if (o !== 32'd1 || v !== 1'b1) begin miss++;
      $display("FAIL slti11 got %h/%b want 1/1", o, v); end
    run1(ei(OP_SLTI, 4, 3, 16'hFFFF), o, rd, f, v);
    vecs++; if (o !== 32'd1) begin miss++;
      $display("FAIL slti_neg got %h want 1", o); end
  endtask

  task automatic test_arith_flags();
    logic [31:0] o; logic [4:0] rd;
    logic [3:0] f; logic v;
    run1(ei(OP_ADDI, 6, 0, 16'hFFFF), o, rd, f, v);
    run1(ei(OP_SHR, 6, 6, 16'd1), o, rd, f, v);
    vecs++; if (o !== 32'h7FFFFFFF || f !== 4'b0000) begin miss++;
      $display("FAIL shr got %h/%b want 7fffffff/0000", o, f); end
    run1(ei(OP_ADDI, 7, 0, 16'd1), o, rd, f, v);
    run1(er(OP_ADD, 5, 6, 7), o, rd, f, v);
    vecs++; if (o !== 32'h80000000 || f !== 4'b1001) begin miss++;
      $display("FAIL add_ovf got %h/%b want 80000000/1001", o, f); end
    run1(er(OP_SUB, 11, 0, 7), o, rd, f, v);
    vecs++; if (o !== 32'hFFFFFFFF || f !== 4'b1000) begin miss++;
      $display("FAIL sub_borrow got %h/%b want ffffffff/1000", o, f); end
    run1(er(OP_SUB, 11, 5, 7), o, rd, f, v);
    vecs++; if (o !== 32'h7FFFFFFF || f !== 4'b0011) begin miss++;
      $display("FAIL sub_ovf got %h/%b want 7fffffff/0011", o, f); end
    run1(ei(OP_SHL, 12, 7, 16'd31), o, rd, f, v);
    vecs++; if (o !== 32'h80000000 || f !== 4'b1000) begin miss++;
      $display("FAIL shl got %h/%b want 80000000/1000", o, f); end
    run1(ei(OP_ADDI, 13, 0, 16'hFFFF), o, rd, f, v);
    run1(ei(OP_ADDI, 13, 13, 16'd1), o, rd, f, v);
    vecs++; if (o !== 32'd0 || f !== 4'b0110) begin miss++;
      $display("FAIL addi_carry got %h/%b want 0/0110", o, f); end
  endtask

  task automatic test_r0_nop();
    logic [31:0] o; logic [4:0] rd;
    logic [3:0] f; logic v;
    run1(ei(OP_ADDI, 0, 0, 16'd5), o, rd, f, v);
    vecs++; if (o !== 32'd5 || rd !== 5'd0 || v !== 1'b1) begin miss++;
      $display("FAIL r0_report got %h/%0d/%b want 5/0/1", o, rd, v); end
    run1(er(OP_MOV, 14, 0, 0), o, rd, f, v);
    vecs++; if (o !== 32'd0) begin miss++;
      $display("FAIL r0_read got %h want 0", o); end
    run1(er(OP_NOP, 1, 1, 1), o, rd, f, v);
    vecs++; if (v !== 1'b0 || illegal !== 1'b0) begin miss++;
      $display("FAIL nop got %b/%b want 0/0", v, illegal); end
  endtask

  task automatic test_mul();
    int low;
    int ovs;
    instr = er(OP_MUL, 8, 1, 1);
    instr_valid = 1'b1;
    tick();
    instr = ei(OP_ADDI, 9, 8, 16'd1);
    low = 0;
    ovs = 0;
    while (!instr_ready && low < 100) begin
      low++;
      tick();
      if (out_valid) ovs++;
    end
    vecs++; if (low != 32) begin miss++;
      $display("FAIL mul_stall got %0d want 32", low); end
    vecs++; if (busy !== 1'b1 || ovs != 0) begin miss++;
      $display("FAIL mul_busy got %b/%0d want 1/0", busy, ovs); end
    tick();
    instr_valid = 1'b0;
    vecs++; if (out !== 32'd100 || out_rd !== 5'd8 ||
                out_valid !== 1'b1) begin miss++;
      $display("FAIL mul_wb got %h/%0d/%b want 64/8/1",
               out, out_rd, out_valid); end
    vecs++; if (busy !== 1'b0 || flags !== 4'b0000) begin miss++;
      $display("FAIL mul_end got %b/%b want 0/0000", busy, flags); end
    tick();
    vecs++; if (out !== 32'd101 || out_rd !== 5'd9) begin miss++;
      $display("FAIL mul_dep got %h/%0d want 65/9", out, out_rd); end
  endtask

  task automatic test_mul_reset();
    logic [31:0] o; logic [4:0] rd;
    logic [3:0] f; logic v;
    int ovs;
    instr = er(OP_MUL, 8, 1, 1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    vecs++; if (busy !== 1'b1) begin miss++;
      $display("FAIL mrst_run got %b want 1", busy); end
    rst = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0 || instr_ready !== 1'b0) begin miss++;
      $display("FAIL mrst_abort got %b/%b want 0/0",
               busy, instr_ready); end
    tick();
    rst = 1'b0;
    ovs = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) ovs++;
      tick();
    end
    vecs++; if (ovs != 0 || busy !== 1'b0) begin miss++;
      $display("FAIL mrst_nowb got %0d/%b want 0/0", ovs, busy); end
    run1(er(OP_MOV, 15, 1, 0), o, rd, f, v);
    vecs++; if (o !== 32'd0 || v !== 1'b1) begin miss++;
      $display("FAIL mrst_r1 got %h/%b want 0/1", o, v); end
    run1(ei(OP_ADDI, 1, 0, 16'd7), o, rd, f, v);
    instr = {6'b111111, 5'd1, 5'd1, 16'h0003};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    vecs++; if (illegal !== 1'b0) begin miss++;
      $display("FAIL ill_early got %b want 0", illegal); end
    tick();
    vecs++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin miss++;
      $display("FAIL ill_pulse got %b/%b want 1/0",
               illegal, out_valid); end
    tick();
    vecs++; if (illegal !== 1'b0) begin miss++;
      $display("FAIL ill_clear got %b want 0", illegal); end
    run1(er(OP_MOV, 15, 1, 0), o, rd, f, v);
    vecs++; if (o !== 32'd7) begin miss++;
      $display("FAIL ill_nowr got %h want 7", o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_logic();
    test_arith_flags();
    test_r0_nop();
    test_mul();
    test_mul_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
